// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
// The state encoding is fixed so that other blocks can decode it.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full subtractor built from two half subtractors.
// The second stage subtracts the incoming borrow from the first-stage difference.
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic d0;
  logic b0;
  logic b1;

  half_sub u_hs0 (
    .a      (a),
    .b      (b),
    .diff   (d0),
    .borrow (b0)
  );

  half_sub u_hs1 (
    .a      (d0),
    .b      (bin),
    .diff   (diff),
    .borrow (b1)
  );

  // Both stages can never borrow at once, so an OR is enough.
  assign bout = b0 | b1;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one full_sub cell is stepped LSB first
// over WIDTH cycles, and a one-cycle done strobe marks the result.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             borrow_out_reg;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             shift_en;
  logic             last_bit;
  logic             cell_diff;
  logic             cell_bout;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_sub u_cell (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (borrow_reg),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The borrow flop restarts each operation; borrow_out only moves on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      borrow_reg     <= 1'b0;
      borrow_out_reg <= 1'b0;
      cnt            <= '0;
    end else if (load) begin
      a_reg      <= a;
      b_reg      <= b;
      borrow_reg <= 1'b0;
      cnt        <= '0;
    end else if (shift_en) begin
      a_reg      <= a_reg >> 1;
      b_reg      <= b_reg >> 1;
      borrow_reg <= cell_bout;
      cnt        <= cnt + CW'(1);
      if (last_bit) begin
        borrow_out_reg <= cell_bout;
      end
    end
  end

  generate
    if (WIDTH == 1) begin : g_diff_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          diff_reg <= '0;
        end else if (shift_en) begin
          diff_reg <= cell_diff;
        end
      end
    end else begin : g_diff_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          diff_reg <= '0;
        end else if (shift_en) begin
          diff_reg <= {cell_diff, diff_reg[WIDTH-1:1]};
        end
      end
    end
  endgenerate

  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);
  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic model: diff = (a - b) mod 2^WIDTH, borrow = (a < b).
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow_out1;

  int checks;
  int errors;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit inject, input string tag);
    logic [8:0] wide;
    logic [7:0] exp_diff;
    logic       exp_borrow;
    wide       = {1'b0, av} + 9'd256 - {1'b0, bv};
    exp_diff   = wide[7:0];
    exp_borrow = (av < bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s shift cycle %0d: busy=%b done=%b, want busy=1 done=0", tag, k, busy, done);
      end
      if (inject && (k == 2 || k == 4)) begin
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || diff !== exp_diff || borrow_out !== exp_borrow) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b diff=%h borrow=%b, want done=1 busy=0 diff=%h borrow=%b",
               tag, done, busy, diff, borrow_out, exp_diff, exp_borrow);
    end else begin
      $display("op %s a=%h b=%h diff=%h borrow=%b", tag, av, bv, diff, borrow_out);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || diff !== exp_diff || borrow_out !== exp_borrow) begin
      errors++;
      $display("FAIL %s idle hold: done=%b busy=%b diff=%h borrow=%b, want done=0 busy=0 diff=%h borrow=%b",
               tag, done, busy, diff, borrow_out, exp_diff, exp_borrow);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    a      = '0;
    b      = '0;
    a1     = '0;
    b1     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || borrow_out1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w1: busy=%b done=%b diff=%b borrow=%b, want all 0", busy1, done1, diff1, borrow_out1);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_directed();
    run_op(8'h05, 8'h03, 1'b0, "dir_05_03");
    run_op(8'h03, 8'h05, 1'b0, "dir_03_05");
    run_op(8'h00, 8'hFF, 1'b0, "dir_00_ff");
    run_op(8'hA5, 8'hA5, 1'b0, "dir_a5_a5");
    run_op(8'hFF, 8'h00, 1'b0, "dir_ff_00");
  endtask

  task automatic test_ignore_start();
    run_op(8'h5A, 8'h13, 1'b1, "ignore_start");
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start extra op: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    a     = 8'h77;
    b     = 8'h22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset after release cycle %0d: done=%b busy=%b, want 0 0", k, done, busy);
      end
      @(posedge clk); #1;
    end
    $display("mid reset abandoned op");
    run_op(8'h40, 8'h41, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(posedge clk); #1;
    for (int op = 0; op < 3; op++) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b op %0d cycle %0d: busy=%b done=%b, want 1 0", op, k, busy, done);
        end
        @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h0F || borrow_out !== 1'b0) begin
        errors++;
        $display("FAIL b2b op %0d result: done=%b busy=%b diff=%h borrow=%b, want 1 0 0f 0",
                 op, done, busy, diff, borrow_out);
      end else begin
        $display("b2b op %0d diff=%h borrow=%b", op, diff, borrow_out);
      end
      if (op == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b stop: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, $sformatf("rand_%0d", n));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_width1();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic       exp_d;
      logic       exp_b;
      ab    = 2'(i);
      exp_d = ab[1] ^ ab[0];
      exp_b = (ab[1] < ab[0]);
      start1 = 1'b1;
      a1     = ab[1];
      b1     = ab[0];
      @(posedge clk); #1;
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1 a=%b b=%b shift: busy=%b done=%b, want 1 0", ab[1], ab[0], busy1, done1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== exp_d || borrow_out1 !== exp_b) begin
        errors++;
        $display("FAIL w1 a=%b b=%b result: done=%b busy=%b diff=%b borrow=%b, want 1 0 %b %b",
                 ab[1], ab[0], done1, busy1, diff1, borrow_out1, exp_d, exp_b);
      end else begin
        $display("w1 a=%b b=%b diff=%b borrow=%b", ab[1], ab[0], diff1, borrow_out1);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller that sequences a single one-bit full-subtractor cell, itself built from two half subtractors, over WIDTH clock cycles to produce an unsigned WIDTH-bit difference and borrow. It accepts operands on a start pulse, processes one bit per cycle LSB first, and reports completion with a one-cycle done strobe. It trades latency for area and serves as the multi-bit front end to the existing half-subtractor datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle strobe in DONE.
- diff  output  WIDTH  result, (a − b) mod 2^WIDTH.
- borrow_out  output  1  final borrow, 1 iff a < b (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: load the a and b shift registers, clear the borrow flop and bit counter, and go to SHIFT. With start=0, remain in IDLE.
- Each SHIFT cycle:
  - The cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - d shifts into the diff register MSB, which shifts right.
  - The a and b registers shift right, bout goes to the borrow flop, and the counter increments.
- SHIFT to DONE: after the cycle where counter == WIDTH−1. At this point diff holds all bits in order and borrow_out takes the final bout.
- DONE: done=1 for exactly one cycle.
  - start=1 here is accepted and behaves as in IDLE, going directly to SHIFT.
  - Otherwise, go to IDLE.
- start while in SHIFT is ignored. a and b changes after capture have no effect.
- diff and borrow_out hold their last result through IDLE until the next DONE. They are not cleared on a new start; they update only as bits shift in, so they are valid only when done=1 or in IDLE after done.
- Counter width is max(1, $clog2(WIDTH)).
- WIDTH=1: one SHIFT cycle; the result equals the half-subtractor truth table.

## Timing
- Reset (async assert, any state): go to IDLE; busy=0, done=0, diff=0, borrow_out=0, internal registers=0. An operation in progress is abandoned with no done.
- Reset deassertion is synchronized externally. The first edge after deassertion may accept start.
- Start accepted at edge E0 → busy=1 from E0 through E0+WIDTH → done=1 during the cycle after edge E0+WIDTH. Latency is WIDTH+1 edges from start to the done cycle.
- Throughput: back-to-back operations every WIDTH+1 cycles when start is held or re-asserted in DONE.
- busy and done are never high simultaneously.

## Structure
- Shared package holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- One sub-module, full_sub: two half_sub instances plus an OR of their borrows.
  - Ports: a, b, bin, diff, bout.
  - Purely combinational; instantiated once inside serial_sub_ctrl.
- All sequencing, shift registers and counter live in serial_sub_ctrl.

## Test plan
- WIDTH=8, a=0x05, b=0x03, one-cycle start → busy for 8 cycles, done on cycle 9, diff=0x02, borrow_out=0.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1; a=0x00, b=0xFF → diff=0x01, borrow_out=1; a=b=0xA5 → diff=0x00, borrow_out=0.
- start pulses at cycles 3 and 5 of SHIFT with different a/b values → ignored; the result corresponds to the originally captured operands and done occurs exactly once.
- rst asserted at cycle 4 of SHIFT → busy, done, diff and borrow_out go to 0 immediately; no done follows. A new start after release produces a correct result.
- start held high continuously with a=0x10, b=0x01 → done every 9 cycles, diff=0x0F each time, and busy=0 only during DONE cycles.
- WIDTH=1, all four a/b combinations → (diff, borrow_out) = (0,0), (1,1), (1,0), (0,0), with done 2 cycles after start.
